// File: rtl/fp32_acc_pkg.sv
// Shared definitions for the FP32 vector accumulator controller:
// FSM state encoding, the +0 constant and the default adder latency.
package fp32_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REDUCE = 2'd2,
        OUT    = 2'd3
    } acc_state_e;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam int          ADD_LAT_DEF   = 3;

    // Width of a partial-sum slot index; at least one bit so ports stay legal.
    function automatic int slot_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/fp32_acc_tag_pipe.sv
// Tag pipeline that follows each adder request through the adder latency,
// so the returning sum can be written into the slot it was issued for.
module fp32_acc_tag_pipe
    import fp32_acc_pkg::*;
#(
    parameter int ADD_LAT = ADD_LAT_DEF,
    localparam int SW     = slot_w(ADD_LAT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [SW-1:0] push_slot,
    output logic          pop_vld,
    output logic [SW-1:0] pop_slot,
    output logic          pend
);

    logic [ADD_LAT-1:0] vld_pipe;
    logic [SW-1:0]      slot_pipe [ADD_LAT];

    // Shift the valid/slot tags one stage per cycle; reset empties the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < ADD_LAT; i++) slot_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= push_vld;
            slot_pipe[0] <= push_slot;
            for (int i = 1; i < ADD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                slot_pipe[i] <= slot_pipe[i-1];
            end
        end
    end

    assign pop_vld  = vld_pipe[ADD_LAT-1];
    assign pop_slot = slot_pipe[ADD_LAT-1];

    // Requests still in flight after this cycle (the popping stage excluded).
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < ADD_LAT - 1; i++) pend = pend | vld_pipe[i];
    end

endmodule

// File: rtl/fp32_acc_ctrl.sv
// FP32 vector accumulator controller around an external pipelined adder.
// Elements are spread round-robin over ADD_LAT partial sums so the adder
// accepts one element per cycle; the partials are then folded into psum[0].
// Optional: define FP32_ACC_ELEM_CNT_EN to add the out_count element count.
module fp32_acc_ctrl
    import fp32_acc_pkg::*;
#(
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        add_valid,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_rsp_valid,
    input  logic [31:0] add_rsp_y,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
`ifdef FP32_ACC_ELEM_CNT_EN
    ,
    output logic [15:0] out_count
`endif
);

    localparam int SW = slot_w(ADD_LAT);
    localparam logic [SW-1:0] LAST_K = SW'((ADD_LAT > 1) ? ADD_LAT - 2 : 0);

    acc_state_e    state;
    logic [31:0]   psum [ADD_LAT];
    logic [SW-1:0] slot_q, red_k, red_b_slot, iss_slot, pop_slot;
    logic          red_wait, pop_vld, pend;
    logic          acc_fire, red_fire, wb_en, out_fire;
    logic [31:0]   fwd_b;

    fp32_acc_tag_pipe #(.ADD_LAT(ADD_LAT)) u_tag (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (add_valid),
        .push_slot (iss_slot),
        .pop_vld   (pop_vld),
        .pop_slot  (pop_slot),
        .pend      (pend)
    );

    // Issue mux: accepted elements in ACCUM, fold steps in REDUCE, else idle zeros.
    always_comb begin
        acc_fire   = in_valid & in_ready;
        red_fire   = (state == REDUCE) & ~red_wait;
        wb_en      = pop_vld & add_rsp_valid;
        out_fire   = (state == OUT) & out_ready;
        red_b_slot = red_k + SW'(1);
        // A sum returning this cycle for the same slot is newer than psum.
        fwd_b      = (wb_en && pop_slot == slot_q) ? add_rsp_y : psum[slot_q];
        add_valid  = 1'b0;
        add_a      = FP32_POS_ZERO;
        add_b      = FP32_POS_ZERO;
        iss_slot   = '0;
        if (acc_fire) begin
            add_valid = 1'b1;
            add_a     = in_data;
            add_b     = fwd_b;
            iss_slot  = slot_q;
        end else if (red_fire) begin
            add_valid = 1'b1;
            add_a     = psum[0];
            add_b     = psum[red_b_slot];
        end
    end

    // Control FSM with registered in_ready / out_valid / out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= FP32_POS_ZERO;
            red_k     <= '0;
            red_wait  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (acc_fire && in_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        if (ADD_LAT == 1) begin
                            // Single partial: the returning sum is the answer.
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_data  <= wb_en ? add_rsp_y : psum[0];
                        end else begin
                            state    <= REDUCE;
                            red_k    <= '0;
                            red_wait <= 1'b0;
                        end
                    end
                end
                REDUCE: begin
                    if (red_fire) begin
                        red_wait <= 1'b1;
                    end else if (wb_en) begin
                        red_wait <= 1'b0;
                        if (red_k == LAST_K) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_data  <= add_rsp_y;
                        end else begin
                            red_k <= red_k + SW'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // Partial sums and round-robin slot index; both restart after each result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) psum[i] <= FP32_POS_ZERO;
            slot_q <= '0;
        end else if (out_fire) begin
            for (int i = 0; i < ADD_LAT; i++) psum[i] <= FP32_POS_ZERO;
            slot_q <= '0;
        end else begin
            if (wb_en) psum[pop_slot] <= add_rsp_y;
            if (acc_fire) slot_q <= (slot_q == SW'(ADD_LAT - 1)) ? '0 : slot_q + SW'(1);
        end
    end

`ifdef FP32_ACC_ELEM_CNT_EN
    logic [15:0] cnt_q;

    // Saturating count of accepted elements, held until the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt_q <= '0;
        else if (out_fire)                   cnt_q <= '0;
        else if (acc_fire && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign out_count = cnt_q;
`else
    // Element counting not built.
`endif

endmodule
